// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encoding and a ceiling-log2 helper for sizing the nibble index.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_adder4.sv
// Combinational 4-bit ripple-carry adder slice with explicit carry in/out.
module nibble_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
    end
  endgenerate

  assign co = c[4];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract sequenced through one 4-bit adder slice, LSB nibble first.
// Optional signed-overflow flag output enabled by defining ADDSUB_OVF_EN.
module nibble_serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? clog2(NIB) : 1;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               carry_out_reg;
  logic               out_valid_reg;
  logic               busy_reg;

  logic [3:0]         a_nib [NIB];
  logic [3:0]         b_nib [NIB];
  logic [NIB-1:0]     nib_we;
  logic [3:0]         nib_sum;
  logic               nib_co;
  logic               last_nib;

  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi]  = a_reg[4*gi +: 4];
      assign b_nib[gi]  = b_reg[4*gi +: 4];
      assign nib_we[gi] = (state_reg == ST_RUN) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  nibble_adder4 u_adder (
    .a   (a_nib[idx_reg]),
    .b   (b_nib[idx_reg]),
    .ci  (carry_reg),
    .sum (nib_sum),
    .co  (nib_co)
  );

  assign last_nib = (idx_reg == IDX_W'(NIB - 1));

`ifdef ADDSUB_OVF_EN
  logic ovf_reg;
  logic ovf_next;

  // b_reg already holds the inverted operand for subtraction.
  assign ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (nib_sum[3] != a_reg[WIDTH-1]);
  assign ovf      = ovf_reg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= op_sub;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Only the current nibble is written; the rest keep their prior value.
          for (int i = 0; i < NIB; i++) begin
            if (nib_we[i]) result_reg[4*i +: 4] <= nib_sum;
          end
          carry_reg <= nib_co;
          if (last_nib) begin
            carry_out_reg <= nib_co;
`ifdef ADDSUB_OVF_EN
            ovf_reg       <= ovf_next;
`endif
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE) && rst;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign carry_out = carry_out_reg;
  assign busy      = busy_reg;

endmodule
